// File: rtl/pitch_frame_sequencer_if.sv
// pitch_frame_sequencer_if
//   Bundles the handshake and bus signals between the frame sequencer and its
//   datapath: codec sample strobe, sample-buffer write port, FFT start/done,
//   FFT result read address, peak-finder enable/frequency, and the report/status
//   outputs.
//   master : sequencer side (drives capture/fft/read/peak/report outputs)
//   slave  : datapath/environment side (drives run, samples, fft_done, peak_frequency)
interface pitch_frame_sequencer_if #(
  parameter int FFT_WIDTH_LOG_2 = 14
);
  logic                       run;
  logic                       sample_valid;
  logic                       capture_we;
  logic [FFT_WIDTH_LOG_2-1:0] capture_addr;
  logic                       fft_start;
  logic                       fft_done;
  logic [FFT_WIDTH_LOG_2-1:0] read_addr;
  logic                       peak_enable;
  logic [15:0]                peak_frequency;
  logic [15:0]                frequency;
  logic                       frequency_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    input  run, sample_valid, fft_done, peak_frequency,
    output capture_we, capture_addr, fft_start, read_addr, peak_enable,
           frequency, frequency_valid, busy, overrun
  );

  modport slave (
    output run, sample_valid, fft_done, peak_frequency,
    input  capture_we, capture_addr, fft_start, read_addr, peak_enable,
           frequency, frequency_valid, busy, overrun
  );
endinterface

// File: rtl/pitch_frame_sequencer.sv
// pitch_frame_sequencer
//   Frame controller for the pitch-detection datapath. Captures FFT_WIDTH codec
//   samples, pulses fft_start, waits for fft_done, scans the lower half of the
//   FFT result memory while enabling the peak finder (aligned to the one-cycle
//   read latency), then latches the peak frequency and pulses frequency_valid.
//   Frames run back-to-back while run is high.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pitch_frame_sequencer_if.master (all handshake/bus signals)
module pitch_frame_sequencer #(
  parameter int FFT_WIDTH       = 16384,
  parameter int FFT_WIDTH_LOG_2 = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  pitch_frame_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURE   = 3'd1,
    TRANSFORM = 3'd2,
    SCAN      = 3'd3,
    FLUSH     = 3'd4,
    REPORT    = 3'd5
  } state_t;

  localparam logic [FFT_WIDTH_LOG_2-1:0] CAP_LAST  = FFT_WIDTH_LOG_2'(FFT_WIDTH - 1);
  localparam logic [FFT_WIDTH_LOG_2-1:0] SCAN_LAST = FFT_WIDTH_LOG_2'(FFT_WIDTH/2 - 1);

  state_t                     state_q;
  logic [FFT_WIDTH_LOG_2-1:0] cap_addr_q, cap_addr_d;
  logic [FFT_WIDTH_LOG_2-1:0] rd_addr_q, rd_addr_d;
  logic                       fft_start_q;
  logic                       peak_en_q;
  logic                       fv_q;
  logic                       ovr_q;
  logic [15:0]                freq_q;

  logic accept;
  logic dropped;

  // A sample is written only while capturing with run still high; a run drop
  // in the same cycle discards it together with the partial frame.
  assign accept  = (state_q == CAPTURE) && bus.run && bus.sample_valid;
  // Samples during the analysis phases of a run cannot be stored.
  assign dropped = bus.run && bus.sample_valid &&
                   ((state_q == TRANSFORM) || (state_q == SCAN) ||
                    (state_q == FLUSH)     || (state_q == REPORT));

  assign cap_addr_d = cap_addr_q + 1'b1;
  assign rd_addr_d  = rd_addr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      rd_addr_q   <= '0;
      fft_start_q <= 1'b0;
      peak_en_q   <= 1'b0;
      fv_q        <= 1'b0;
      ovr_q       <= 1'b0;
      freq_q      <= 16'd0;
    end else begin
      fft_start_q <= 1'b0;
      fv_q        <= 1'b0;
      // Read data lags the address by one cycle, so the enable lags SCAN by one:
      // high from the 2nd SCAN cycle through FLUSH, low in REPORT.
      peak_en_q   <= (state_q == SCAN);
      if (dropped) ovr_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q    <= CAPTURE;
            cap_addr_q <= '0;
            ovr_q      <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!bus.run) begin
            state_q <= IDLE;
          end else if (bus.sample_valid) begin
            // Terminal sample: hold the address instead of wrapping.
            if (cap_addr_q == CAP_LAST) begin
              state_q     <= TRANSFORM;
              fft_start_q <= 1'b1;
            end else begin
              cap_addr_q <= cap_addr_d;
            end
          end
        end
        TRANSFORM: begin
          if (bus.fft_done) begin
            state_q   <= SCAN;
            rd_addr_q <= '0;
          end
        end
        SCAN: begin
          if (rd_addr_q == SCAN_LAST) state_q <= FLUSH;
          else                        rd_addr_q <= rd_addr_d;
        end
        FLUSH: state_q <= REPORT;
        REPORT: begin
          freq_q <= bus.peak_frequency;
          fv_q   <= 1'b1;
          if (bus.run) begin
            state_q    <= CAPTURE;
            cap_addr_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.capture_we      = accept;
  assign bus.capture_addr    = cap_addr_q;
  assign bus.fft_start       = fft_start_q;
  assign bus.read_addr       = rd_addr_q;
  assign bus.peak_enable     = peak_en_q;
  assign bus.frequency       = freq_q;
  assign bus.frequency_valid = fv_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.overrun         = ovr_q;

endmodule

// File: tb/tb_pitch_frame_sequencer.sv
// tb_pitch_frame_sequencer
//   Directed scenarios followed by randomized traffic. A timeline-level model
//   (phase + samples captured + cycles since fft_done) predicts every output and
//   is compared each cycle; literal expectations pin key scenario results.
module tb_pitch_frame_sequencer;
  localparam int W = 16;
  localparam int L = 4;
  localparam int H = W / 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pitch_frame_sequencer_if #(.FFT_WIDTH_LOG_2(L)) bus ();

  pitch_frame_sequencer #(.FFT_WIDTH(W), .FFT_WIDTH_LOG_2(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame timeline after fft_done: t = 0..H-1 scan, t = H flush, t = H+1 report.
  typedef enum int {M_IDLE, M_CAP, M_XF, M_POST} mph_t;
  mph_t        m_ph    = M_IDLE;
  int          m_cnt   = 0;
  int          m_t     = 0;
  bit          m_first = 0;
  logic [15:0] m_freq  = 16'd0;
  bit          m_fv    = 0;
  bit          m_ovr   = 0;
  bit          nf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = M_IDLE; m_cnt = 0; m_t = 0; m_first = 0;
      m_freq = 16'd0; m_fv = 0; m_ovr = 0;
    end else begin
      m_fv = 0;
      nf   = 0;
      if (bus.sample_valid && bus.run && (m_ph == M_XF || m_ph == M_POST)) m_ovr = 1;
      case (m_ph)
        M_IDLE: if (bus.run) begin m_ph = M_CAP; m_cnt = 0; m_ovr = 0; end
        M_CAP: begin
          if (!bus.run) m_ph = M_IDLE;
          else if (bus.sample_valid) begin
            if (m_cnt == W - 1) begin m_ph = M_XF; nf = 1; end
            else m_cnt++;
          end
        end
        M_XF: if (bus.fft_done) begin m_ph = M_POST; m_t = 0; end
        M_POST: begin
          if (m_t == H + 1) begin
            m_freq = bus.peak_frequency;
            m_fv   = 1;
            if (bus.run) begin m_ph = M_CAP; m_cnt = 0; end
            else m_ph = M_IDLE;
          end else m_t++;
        end
        default: m_ph = M_IDLE;
      endcase
      m_first = nf;
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int n_fv = 0, n_fs = 0, n_pe = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy",       32'(bus.busy),       32'(m_ph != M_IDLE));
      chk("capture_we", 32'(bus.capture_we), 32'(m_ph == M_CAP && bus.sample_valid && bus.run));
      if (m_ph == M_CAP) chk("capture_addr", 32'(bus.capture_addr), m_cnt);
      chk("fft_start",  32'(bus.fft_start),  32'(m_first));
      if (m_ph == M_POST) chk("read_addr", 32'(bus.read_addr), (m_t < H - 1) ? m_t : H - 1);
      chk("peak_enable", 32'(bus.peak_enable), 32'(m_ph == M_POST && m_t >= 1 && m_t <= H));
      chk("frequency",  32'(bus.frequency),  32'(m_freq));
      chk("frequency_valid", 32'(bus.frequency_valid), 32'(m_fv));
      chk("overrun",    32'(bus.overrun),    32'(m_ovr));
      if (bus.frequency_valid) n_fv++;
      if (bus.fft_start)       n_fs++;
      if (bus.peak_enable)     n_pe++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fv(input int budget);
    int k = 0;
    while (!bus.frequency_valid && k < budget) begin cyc(1); k++; end
    chk("fv_timeout", 32'(bus.frequency_valid), 32'd1);
  endtask

  initial begin
    int fv_snap;
    bus.run = 0; bus.sample_valid = 0; bus.fft_done = 0; bus.peak_frequency = 16'd0;
    cyc(2);
    reset = 0;
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_freq",   32'(bus.frequency), 0);
    chk("rst_ovr",    32'(bus.overrun), 0);
    chk("rst_caddr",  32'(bus.capture_addr), 0);
    chk("rst_pe",     32'(bus.peak_enable), 0);

    // Normal frame: 16 samples spaced 3 cycles, fft_done 5 cycles after start.
    bus.peak_frequency = 16'd1500;
    bus.run = 1;
    cyc(1);
    for (int i = 0; i < W; i++) begin
      bus.sample_valid = 1; cyc(1); bus.sample_valid = 0; cyc(2);
    end
    chk("f1_fs_count", n_fs, 1);
    cyc(3);
    bus.fft_done = 1; cyc(1); bus.fft_done = 0;
    wait_fv(40);
    chk("f1_freq", 32'(bus.frequency), 1500);
    cyc(1);
    chk("f1_fv_count", n_fv, 1);
    chk("f1_pe_count", n_pe, 8);
    chk("f2_caddr0",   32'(bus.capture_addr), 0);
    chk("f2_busy",     32'(bus.busy), 1);

    // Back-to-back frame, fft_done with fft_start, run falls during SCAN.
    bus.peak_frequency = 16'd2929;
    bus.sample_valid = 1; cyc(W);
    bus.sample_valid = 0;
    chk("f2_fs_now", 32'(bus.fft_start), 1);
    bus.fft_done = 1; cyc(1); bus.fft_done = 0;
    chk("f2_scan_raddr", 32'(bus.read_addr), 0);
    chk("f2_scan_pe0",   32'(bus.peak_enable), 0);
    cyc(1);
    chk("f2_scan_pe1",   32'(bus.peak_enable), 1);
    cyc(1);
    bus.run = 0;
    wait_fv(40);
    chk("f2_freq", 32'(bus.frequency), 2929);
    cyc(1);
    chk("f2_fv_count", n_fv, 2);
    chk("f2_pe_count", n_pe, 16);
    chk("f2_idle",     32'(bus.busy), 0);

    // Abort in capture after 7 samples; sample in the drop cycle is not written.
    bus.run = 1; cyc(1);
    for (int i = 0; i < 7; i++) begin
      bus.sample_valid = 1; cyc(1); bus.sample_valid = 0; cyc(1);
    end
    bus.run = 0; bus.sample_valid = 1; cyc(1); bus.sample_valid = 0;
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_freq", 32'(bus.frequency), 2929);
    cyc(2);
    chk("ab_fs_count", n_fs, 2);

    // Overrun: sample during SCAN, survives REPORT->CAPTURE, clears on IDLE->CAPTURE.
    bus.peak_frequency = 16'd777;
    bus.run = 1; cyc(1);
    bus.sample_valid = 1; cyc(W); bus.sample_valid = 0;
    cyc(2);
    bus.fft_done = 1; cyc(1); bus.fft_done = 0;
    cyc(2);
    bus.sample_valid = 1; cyc(1); bus.sample_valid = 0;
    chk("ov_set", 32'(bus.overrun), 1);
    wait_fv(40);
    chk("ov_hold_cap",  32'(bus.overrun), 1);
    chk("ov_busy_cap",  32'(bus.busy), 1);
    bus.run = 0; cyc(1);
    chk("ov_hold_idle", 32'(bus.overrun), 1);
    bus.run = 1; cyc(1);
    chk("ov_clear",     32'(bus.overrun), 0);

    // Async reset mid-SCAN: outputs drop without waiting for a clock edge.
    bus.sample_valid = 1; cyc(W); bus.sample_valid = 0;
    bus.fft_done = 1; cyc(1); bus.fft_done = 0;
    cyc(3);
    chk("ar_pe_before", 32'(bus.peak_enable), 1);
    chk("ar_freq_before", 32'(bus.frequency), 777);
    fv_snap = n_fv;
    #2 reset = 1;
    #1;
    chk("ar_pe",   32'(bus.peak_enable), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_fv",   32'(bus.frequency_valid), 0);
    chk("ar_freq", 32'(bus.frequency), 0);
    bus.run = 0;
    #4 reset = 0;
    cyc(20);
    chk("ar_no_report", n_fv, fv_snap);
    chk("ar_idle",      32'(bus.busy), 0);

    // Randomized traffic, checked by the model every cycle.
    bus.run = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 2) bus.run = ~bus.run;
      bus.sample_valid   = ($urandom_range(0, 2) != 0);
      bus.fft_done       = ($urandom_range(0, 4) == 0);
      bus.peak_frequency = 16'($urandom);
      cyc(1);
    end
    bus.run = 0; bus.sample_valid = 0; bus.fft_done = 0;
    cyc(40);
    chk("rnd_frames_seen", 32'(n_fv > 4), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pitch_frame_sequencer.md
Name: pitch_frame_sequencer

Overview:
- Frame-level controller for the pitch-detection datapath.
- Capture phase: fills the sample buffer with FFT_WIDTH codec samples, then triggers the FFT core.
- Scan phase: reads the lower half of the FFT result memory and drives the peak finder's enable, aligned to the one-cycle memory read latency.
- Report phase: latches the peak finder's frequency and pulses frequency_valid. Runs frames back-to-back while run is high.

Parameters:
- FFT_WIDTH, 16384, samples per frame and FFT points; power of two, ≥ 8.
- FFT_WIDTH_LOG_2, 14, log2(FFT_WIDTH); width of all address outputs.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; high = capture and analyse frames continuously.
- sample_valid  input  1  one-cycle strobe per new codec sample.
- capture_we  output  1  sample buffer write enable.
- capture_addr  output  FFT_WIDTH_LOG_2  sample buffer write address.
- fft_start  output  1  one-cycle pulse starting the FFT core.
- fft_done  input  1  one-cycle pulse from the FFT core; results are ready.
- read_addr  output  FFT_WIDTH_LOG_2  FFT result memory read address. Data returns 1 cycle later.
- peak_enable  output  1  enable to the peak finder.
- peak_frequency  input  16  registered frequency output of the peak finder.
- frequency  output  16  last reported frequency.
- frequency_valid  output  1  one-cycle pulse when frequency updates.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky flag: a sample arrived while not capturing during a run.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE.
  - All address counters = 0.
  - capture_we, fft_start, peak_enable, frequency_valid, busy, overrun = 0.
  - frequency = 16'd0.
- Reset mid-operation abandons the frame. Nothing is reported.
- IDLE:
  - When run = 1: go to CAPTURE, clear overrun, set capture_addr = 0.
- CAPTURE:
  - capture_we = sample_valid (combinational, same cycle).
  - capture_addr increments after each accepted sample.
  - The sample accepted at capture_addr = FFT_WIDTH-1 triggers the move to TRANSFORM. fft_start is high for exactly the first TRANSFORM cycle.
  - If run = 0 in CAPTURE: return to IDLE, discard the partial frame, no fft_start. A sample arriving in that same cycle is not written.
- TRANSFORM:
  - Wait for fft_done.
  - fft_done seen in the same cycle as fft_start is valid and accepted.
  - On fft_done: go to SCAN with read_addr = 0.
  - fft_done outside TRANSFORM is ignored.
- SCAN:
  - Lasts exactly FFT_WIDTH/2 cycles. read_addr = 0, 1, …, FFT_WIDTH/2-1, one per cycle.
  - peak_enable is a 1-cycle registered delay of "in SCAN". It is high from the 2nd SCAN cycle through the FLUSH cycle, for FFT_WIDTH/2 consecutive cycles total, so each enabled cycle sees bin data k = its enable index.
- FLUSH:
  - One cycle. peak_enable stays high for the last bin. read_addr holds FFT_WIDTH/2-1.
- REPORT:
  - One cycle with peak_enable = 0. This low cycle also resets the peak finder's counter between frames.
  - At the end of REPORT: frequency ← peak_frequency and frequency_valid = 1 for the following cycle only.
  - Next state is CAPTURE if run = 1 (capture_addr = 0), otherwise IDLE.
  - run = 0 during TRANSFORM, SCAN or FLUSH does not abort; the frame completes and reports.
- overrun:
  - Set when sample_valid = 1 and run = 1 while state ∈ {TRANSFORM, SCAN, FLUSH, REPORT}.
  - Held until the next IDLE→CAPTURE transition or reset. A REPORT→CAPTURE transition does not clear it.
  - Samples in those states are dropped.
- Address counters are FFT_WIDTH_LOG_2 bits wide and must never wrap inside a phase. The phase transition happens on the terminal count.
- fft_start never asserts outside the first TRANSFORM cycle. peak_enable never asserts outside the SCAN+1 … FLUSH window.

Test Plan (FFT_WIDTH = 16, FFT_WIDTH_LOG_2 = 4):
- Normal frame:
  - Stimulus: reset, run = 1, 16 sample_valid strobes spaced 3 cycles apart.
  - Response: capture_we pulses with addr 0..15; fft_start is a single pulse the cycle after the 16th sample.
  - Stimulus: fft_done 5 cycles later.
  - Response: read_addr 0..7 over 8 cycles; peak_enable high for 8 cycles starting one cycle later.
  - Stimulus: peak_frequency = 16'd1500.
  - Response: frequency = 1500 with a single frequency_valid pulse.
- Back-to-back frames:
  - Stimulus: run stays high; second frame with peak_frequency = 16'd2929.
  - Response: second CAPTURE starts with capture_addr = 0; frequency_valid pulses twice; peak_enable is low for ≥ 1 cycle between frames.
- Abort in capture:
  - Stimulus: drop run after 7 samples.
  - Response: IDLE, busy = 0, no fft_start; frequency is unchanged from its previous value.
- Overrun:
  - Stimulus: sample_valid during SCAN.
  - Response: overrun = 1 and no capture_we. overrun stays 1 through REPORT→CAPTURE and clears on the next IDLE→CAPTURE.
- Simultaneous events:
  - Stimulus: fft_done in the same cycle as fft_start.
  - Response: SCAN entered on the next cycle.
  - Stimulus: run falls during SCAN.
  - Response: frame completes, reports, then IDLE.
- Async reset:
  - Stimulus: assert reset mid-SCAN between clock edges.
  - Response: peak_enable, busy and frequency_valid go to 0 immediately; frequency = 0; no report follows.
